// File: rtl/dsp_decode_stage.sv
// dsp_decode_stage: registered decode stage between fetch and the ALU/MEM stage.
// Decodes the 32-bit instruction word, drives the register-file read addresses
// combinationally from it, and captures operands and control into one output
// pipeline register guarded by a valid/ready handshake. A load whose result is
// read by the very next instruction gets a one-cycle bubble. Undefined opcodes
// are issued as a NOP bundle with `illegal` set. `flush` kills the held bundle
// and the incoming instruction.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            kill held/incoming instruction
//   in_valid / in_ready              fetch-side handshake
//   instruction                      32-bit instruction word
//   reg_addr1/2/3, rd_data1/2/3      regfile read ports (same-cycle data)
//   out_valid / out_ready            downstream handshake
//   alu_mode, mem_mode, flow_mode,
//   write_back_en, reg_dest, shamt,
//   data_s1/s2/s3, jaddress, illegal decoded bundle (registered)
// Opcode = instruction[31:26]; R1 = [25:21], R2 = [20:16], R3 = [15:11], Lit = [15:0].
module dsp_decode_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 5,
    parameter int SEXT_IMM = 0,
    parameter int ACC_REG  = 31,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic [REG_AW-1:0] reg_addr1,
    output logic [REG_AW-1:0] reg_addr2,
    output logic [REG_AW-1:0] reg_addr3,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] rd_data3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        alu_mode,
    output logic [2:0]        mem_mode,
    output logic [2:0]        flow_mode,
    output logic              write_back_en,
    output logic [REG_AW-1:0] reg_dest,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] data_s1,
    output logic [DATA_W-1:0] data_s2,
    output logic [DATA_W-1:0] data_s3,
    output logic [15:0]       jaddress,
    output logic              illegal
);

    localparam logic [5:0] OP_NOP  = 6'h00, OP_ADD  = 6'h01, OP_SUB  = 6'h02, OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04, OP_XOR  = 6'h05, OP_MUL  = 6'h06, OP_SQR  = 6'h07;
    localparam logic [5:0] OP_MAC  = 6'h08, OP_SHL  = 6'h09, OP_SHR  = 6'h0A, OP_ROL  = 6'h0B;
    localparam logic [5:0] OP_ROR  = 6'h0C, OP_ADDI = 6'h10, OP_SUBI = 6'h11, OP_ANDI = 6'h12;
    localparam logic [5:0] OP_ORI  = 6'h13, OP_XORI = 6'h14, OP_LD   = 6'h20, OP_ST   = 6'h21;
    localparam logic [5:0] OP_LDI  = 6'h22, OP_JMP  = 6'h30, OP_BEZ  = 6'h31, OP_BNEZ = 6'h32;
    localparam logic [5:0] OP_BEQ  = 6'h33;

    localparam logic [7:0] ALU_NOP = 8'h00, ALU_ADD = 8'h01, ALU_SUB = 8'h02, ALU_AND = 8'h03;
    localparam logic [7:0] ALU_OR  = 8'h04, ALU_XOR = 8'h05, ALU_MUL = 8'h06, ALU_SQR = 8'h07;
    localparam logic [7:0] ALU_MAC = 8'h08, ALU_SHL = 8'h09, ALU_SHR = 8'h0A, ALU_ROL = 8'h0B;
    localparam logic [7:0] ALU_ROR = 8'h0C, ALU_PASS = 8'h0D;

    localparam logic [2:0] MEM_NONE = 3'd0, MEM_LD = 3'd1, MEM_ST = 3'd2;
    localparam logic [2:0] FLOW_NONE = 3'd0, FLOW_JMP = 3'd1, FLOW_BEZ = 3'd2;
    localparam logic [2:0] FLOW_BNEZ = 3'd3, FLOW_BEQ = 3'd4;

    localparam logic [REG_AW-1:0] ACC_ADDR = REG_AW'(ACC_REG);

    typedef struct packed {
        logic              ill;
        logic [7:0]        alu;
        logic [2:0]        mem;
        logic [2:0]        flow;
        logic              wb;
        logic [REG_AW-1:0] dest;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
        logic [DATA_W-1:0] s3;
        logic [15:0]       jaddr;
    } bundle_t;

    // ALU_NOP, MEM_NONE and FLOW_NONE are all zero, so the NOP bundle is all zeros.
    localparam bundle_t NOP_BUNDLE = '0;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

    function automatic logic [7:0] op_alu(input logic [5:0] op);
        logic [7:0] alu;
        case (op)
            OP_ADD, OP_ADDI: alu = ALU_ADD;
            OP_SUB, OP_SUBI: alu = ALU_SUB;
            OP_AND, OP_ANDI: alu = ALU_AND;
            OP_OR,  OP_ORI:  alu = ALU_OR;
            OP_XOR, OP_XORI: alu = ALU_XOR;
            OP_MUL:          alu = ALU_MUL;
            OP_SQR:          alu = ALU_SQR;
            OP_MAC:          alu = ALU_MAC;
            OP_SHL:          alu = ALU_SHL;
            OP_SHR:          alu = ALU_SHR;
            OP_ROL:          alu = ALU_ROL;
            OP_ROR:          alu = ALU_ROR;
            OP_LDI:          alu = ALU_PASS;
            default:         alu = ALU_NOP;
        endcase
        return alu;
    endfunction

    logic [5:0]        opcode_s;
    logic [REG_AW-1:0] f_r1_s, f_r2_s, f_r3_s;
    logic [DATA_W-1:0] lit_s;
    logic [REG_AW-1:0] addr1_s, addr2_s, addr3_s;
    logic              use1_s, use2_s, use3_s;
    bundle_t           dec_s;
    bundle_t           bundle_r;
    logic              out_valid_r;
    state_t            state_r, state_nxt_s;
    logic              lu_hit_s, bubble_now_s, load_s, accept_s;

    assign opcode_s = instruction[31:26];
    assign f_r1_s   = REG_AW'(instruction[25:21]);
    assign f_r2_s   = REG_AW'(instruction[20:16]);
    assign f_r3_s   = REG_AW'(instruction[15:11]);

    // Immediate extension to the datapath width.
    always_comb begin
        if (SEXT_IMM != 0) begin
            lit_s = DATA_W'($signed(instruction[15:0]));
        end else begin
            lit_s = DATA_W'(instruction[15:0]);
        end
    end

    // Instruction decode: read addresses, port-use flags and the candidate bundle.
    always_comb begin
        dec_s   = NOP_BUNDLE;
        addr1_s = '0;
        addr2_s = '0;
        addr3_s = '0;
        use1_s  = 1'b0;
        use2_s  = 1'b0;
        use3_s  = 1'b0;
        case (opcode_s)
            OP_NOP: dec_s = NOP_BUNDLE;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_MAC: begin
                addr1_s = f_r1_s;   use1_s = 1'b1;
                addr2_s = f_r2_s;   use2_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.s2 = rd_data2;
                dec_s.dest = f_r3_s;
                dec_s.wb = 1'b1;
                dec_s.shamt = instruction[10:6];
                if (opcode_s == OP_MAC) begin
                    addr3_s = ACC_ADDR; use3_s = 1'b1;
                    dec_s.s3 = rd_data3;
                end else begin
                    dec_s.s3 = '0;
                end
            end
            OP_SQR: begin
                addr1_s = f_r1_s;   use1_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.s2 = rd_data1;
                dec_s.dest = f_r3_s;
                dec_s.wb = 1'b1;
                dec_s.shamt = instruction[10:6];
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                addr1_s = f_r1_s;   use1_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.dest = f_r3_s;
                dec_s.wb = 1'b1;
                dec_s.shamt = instruction[10:6];
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                addr1_s = f_r1_s;   use1_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.s2 = lit_s;
                dec_s.dest = f_r2_s;
                dec_s.wb = 1'b1;
            end
            OP_LD: begin
                // Address register comes from the R2 field, result goes to R1.
                addr1_s = f_r2_s;   use1_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.dest = f_r1_s;
                dec_s.wb = 1'b1;
                dec_s.mem = MEM_LD;
            end
            OP_ST: begin
                // R2 holds the address, R1 the store data.
                addr1_s = f_r1_s;   use1_s = 1'b1;
                addr2_s = f_r2_s;   use2_s = 1'b1;
                dec_s.s1 = rd_data2;
                dec_s.s2 = rd_data1;
                dec_s.mem = MEM_ST;
            end
            OP_LDI: begin
                dec_s.s1 = lit_s;
                dec_s.dest = f_r1_s;
                dec_s.wb = 1'b1;
            end
            OP_JMP: begin
                dec_s.jaddr = instruction[15:0];
                dec_s.flow = FLOW_JMP;
            end
            OP_BEZ, OP_BNEZ: begin
                addr1_s = f_r1_s;   use1_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.jaddr = instruction[15:0];
                dec_s.flow = (opcode_s == OP_BEZ) ? FLOW_BEZ : FLOW_BNEZ;
            end
            OP_BEQ: begin
                addr1_s = f_r1_s;   use1_s = 1'b1;
                addr2_s = f_r2_s;   use2_s = 1'b1;
                dec_s.s1 = rd_data1;
                dec_s.s2 = rd_data2;
                dec_s.jaddr = instruction[15:0];
                dec_s.flow = FLOW_BEQ;
            end
            default: dec_s.ill = 1'b1;
        endcase
        dec_s.alu = op_alu(opcode_s);
    end

    assign reg_addr1 = addr1_s;
    assign reg_addr2 = addr2_s;
    assign reg_addr3 = addr3_s;

    // Load-use detection: held bundle is a writing load and an incoming used port reads its dest.
    always_comb begin
        lu_hit_s = (LU_STALL != 0) && out_valid_r && (bundle_r.mem == MEM_LD) && bundle_r.wb &&
                   in_valid && ((use1_s && (addr1_s == bundle_r.dest)) ||
                                (use2_s && (addr2_s == bundle_r.dest)) ||
                                (use3_s && (addr3_s == bundle_r.dest)));
    end

    assign load_s   = ~out_valid_r | out_ready;
    assign in_ready = load_s & ~bubble_now_s & ~flush;
    assign accept_s = in_valid & in_ready;

    // Hazard FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hazard FSM next state: a bubble is only committed when the register advances.
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_RUN;
                end else if (bubble_now_s && load_s) begin
                    state_nxt_s = ST_BUBBLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_BUBBLE: state_nxt_s = ST_RUN;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Hazard FSM output: stall fetch only while running.
    always_comb begin
        bubble_now_s = 1'b0;
        case (state_r)
            ST_RUN:    bubble_now_s = lu_hit_s;
            ST_BUBBLE: bubble_now_s = 1'b0;
            default:   bubble_now_s = 1'b0;
        endcase
    end

    // Output pipeline register; flush beats every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            bundle_r    <= NOP_BUNDLE;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            bundle_r    <= NOP_BUNDLE;
        end else if (load_s) begin
            out_valid_r <= accept_s;
            bundle_r    <= accept_s ? dec_s : NOP_BUNDLE;
        end
    end

    assign out_valid     = out_valid_r;
    assign illegal       = bundle_r.ill;
    assign alu_mode      = bundle_r.alu;
    assign mem_mode      = bundle_r.mem;
    assign flow_mode     = bundle_r.flow;
    assign write_back_en = bundle_r.wb;
    assign reg_dest      = bundle_r.dest;
    assign shamt         = bundle_r.shamt;
    assign data_s1       = bundle_r.s1;
    assign data_s2       = bundle_r.s2;
    assign data_s3       = bundle_r.s3;
    assign jaddress      = bundle_r.jaddr;

endmodule

// File: tb/tb_dsp_decode_stage.sv
// Bench for dsp_decode_stage: a transaction-level model predicts every bundle,
// in_ready and the read addresses each cycle; literal checks pin the model.
// A second instance with SEXT_IMM=0 / LU_STALL=0 is checked at directed points.
module tb_dsp_decode_stage;

    localparam int DW = 32;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [4:0]  reg_addr1, reg_addr2, reg_addr3;
    logic [DW-1:0] rd_data1, rd_data2, rd_data3;
    logic in_ready, out_valid, write_back_en, illegal;
    logic [7:0] alu_mode;
    logic [2:0] mem_mode, flow_mode;
    logic [4:0] reg_dest, shamt;
    logic [DW-1:0] data_s1, data_s2, data_s3;
    logic [15:0] jaddress;

    logic [4:0]  reg_addr1_b, reg_addr2_b, reg_addr3_b;
    logic [DW-1:0] rd_data1_b, rd_data2_b, rd_data3_b;
    logic in_ready_b, out_valid_b, write_back_en_b, illegal_b;
    logic [7:0] alu_mode_b;
    logic [2:0] mem_mode_b, flow_mode_b;
    logic [4:0] reg_dest_b, shamt_b;
    logic [DW-1:0] data_s1_b, data_s2_b, data_s3_b;
    logic [15:0] jaddress_b;

    logic [DW-1:0] rf [0:31];
    assign rd_data1 = rf[reg_addr1];
    assign rd_data2 = rf[reg_addr2];
    assign rd_data3 = rf[reg_addr3];
    assign rd_data1_b = rf[reg_addr1_b];
    assign rd_data2_b = rf[reg_addr2_b];
    assign rd_data3_b = rf[reg_addr3_b];

    always #5 clk = ~clk;

    dsp_decode_stage #(.DATA_W(DW), .REG_AW(5), .SEXT_IMM(1), .ACC_REG(31), .LU_STALL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2), .reg_addr3(reg_addr3),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3), .out_valid(out_valid),
        .out_ready(out_ready), .alu_mode(alu_mode), .mem_mode(mem_mode), .flow_mode(flow_mode),
        .write_back_en(write_back_en), .reg_dest(reg_dest), .shamt(shamt), .data_s1(data_s1),
        .data_s2(data_s2), .data_s3(data_s3), .jaddress(jaddress), .illegal(illegal));

    dsp_decode_stage #(.DATA_W(DW), .REG_AW(5), .SEXT_IMM(0), .ACC_REG(31), .LU_STALL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instruction(instruction), .reg_addr1(reg_addr1_b), .reg_addr2(reg_addr2_b), .reg_addr3(reg_addr3_b),
        .rd_data1(rd_data1_b), .rd_data2(rd_data2_b), .rd_data3(rd_data3_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .alu_mode(alu_mode_b), .mem_mode(mem_mode_b), .flow_mode(flow_mode_b),
        .write_back_en(write_back_en_b), .reg_dest(reg_dest_b), .shamt(shamt_b), .data_s1(data_s1_b),
        .data_s2(data_s2_b), .data_s3(data_s3_b), .jaddress(jaddress_b), .illegal(illegal_b));

    // Opcodes of the ISA.
    localparam logic [5:0] ADD = 6'h01, SUB = 6'h02, XOR_ = 6'h05, ADDI = 6'h10, LD = 6'h20;

    typedef struct packed {
        logic ill; logic [7:0] alu; logic [2:0] mem; logic [2:0] flow; logic wb;
        logic [4:0] dest; logic [4:0] shamt; logic [31:0] s1; logic [31:0] s2; logic [31:0] s3;
        logic [15:0] j;
    } bnd_t;

    int checks = 0, errors = 0;
    logic exp_valid = 1'b0;
    bnd_t exp_b = '0;
    logic last_in_ready, last_in_ready_b;

    logic [5:0] legal_ops [25] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                  6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14,
                                  6'h20, 6'h21, 6'h22, 6'h30, 6'h31, 6'h32, 6'h33};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction classes of the ISA.
    localparam int K_NOP = 0, K_RRR = 1, K_MAC = 2, K_SQR = 3, K_SH = 4, K_IMM = 5, K_LD = 6;
    localparam int K_ST = 7, K_LDI = 8, K_JMP = 9, K_BZ = 10, K_BEQ = 11, K_ILL = 12;

    function automatic int kind_of(input logic [5:0] op);
        if (op == 6'h00) return K_NOP;
        if (op >= 6'h01 && op <= 6'h06) return K_RRR;
        if (op == 6'h07) return K_SQR;
        if (op == 6'h08) return K_MAC;
        if (op >= 6'h09 && op <= 6'h0C) return K_SH;
        if (op >= 6'h10 && op <= 6'h14) return K_IMM;
        if (op == 6'h20) return K_LD;
        if (op == 6'h21) return K_ST;
        if (op == 6'h22) return K_LDI;
        if (op == 6'h30) return K_JMP;
        if (op == 6'h31 || op == 6'h32) return K_BZ;
        if (op == 6'h33) return K_BEQ;
        return K_ILL;
    endfunction

    // Registers read by an instruction, per read port (0 on unused ports).
    function automatic void srcs(input logic [31:0] ins, output logic [4:0] a1, output logic [4:0] a2,
                                 output logic [4:0] a3, output bit u1, output bit u2, output bit u3);
        int k = kind_of(ins[31:26]);
        a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; u1 = 0; u2 = 0; u3 = 0;
        if (k inside {K_RRR, K_MAC, K_SQR, K_SH, K_IMM, K_ST, K_BZ, K_BEQ}) begin
            a1 = ins[25:21]; u1 = 1;
        end
        if (k == K_LD) begin a1 = ins[20:16]; u1 = 1; end
        if (k inside {K_RRR, K_MAC, K_ST, K_BEQ}) begin a2 = ins[20:16]; u2 = 1; end
        if (k == K_MAC) begin a3 = 5'd31; u3 = 1; end
    endfunction

    // Expected bundle for an instruction given the current register file.
    function automatic bnd_t model(input logic [31:0] ins);
        bnd_t b = '0;
        logic [5:0] op = ins[31:26];
        logic [4:0] r1 = ins[25:21], r2 = ins[20:16], r3 = ins[15:11];
        logic [31:0] lit = {{16{ins[15]}}, ins[15:0]};
        int k = kind_of(op);
        case (k)
            K_RRR, K_MAC: begin b.s1 = rf[r1]; b.s2 = rf[r2]; b.dest = r3; b.wb = 1; b.shamt = ins[10:6];
                                if (k == K_MAC) b.s3 = rf[31]; end
            K_SQR:  begin b.s1 = rf[r1]; b.s2 = rf[r1]; b.dest = r3; b.wb = 1; b.shamt = ins[10:6]; end
            K_SH:   begin b.s1 = rf[r1]; b.dest = r3; b.wb = 1; b.shamt = ins[10:6]; end
            K_IMM:  begin b.s1 = rf[r1]; b.s2 = lit; b.dest = r2; b.wb = 1; end
            K_LD:   begin b.s1 = rf[r2]; b.dest = r1; b.wb = 1; b.mem = 3'd1; end
            K_ST:   begin b.s1 = rf[r2]; b.s2 = rf[r1]; b.mem = 3'd2; end
            K_LDI:  begin b.s1 = lit; b.dest = r1; b.wb = 1; b.alu = 8'h0D; end
            K_JMP:  begin b.j = ins[15:0]; b.flow = 3'd1; end
            K_BZ:   begin b.s1 = rf[r1]; b.j = ins[15:0]; b.flow = 3'(op - 6'h2F); end
            K_BEQ:  begin b.s1 = rf[r1]; b.s2 = rf[r2]; b.j = ins[15:0]; b.flow = 3'd4; end
            K_ILL:  b.ill = 1;
            default: b = '0;
        endcase
        if (k inside {K_RRR, K_MAC, K_SQR, K_SH}) b.alu = 8'(op);
        if (k == K_IMM) b.alu = 8'(op - 6'h0F);
        return b;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance the model, check the bundle.
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        logic [4:0] a1, a2, a3; bit u1, u2, u3; logic hz, ld; bnd_t nb;
        @(negedge clk);
        in_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
        #1;
        srcs(ins, a1, a2, a3, u1, u2, u3);
        chk("reg_addr1", 32'(reg_addr1), 32'(a1));
        chk("reg_addr2", 32'(reg_addr2), 32'(a2));
        chk("reg_addr3", 32'(reg_addr3), 32'(a3));
        hz = exp_valid && exp_b.mem == 3'd1 && exp_b.wb && iv &&
             ((u1 && a1 == exp_b.dest) || (u2 && a2 == exp_b.dest) || (u3 && a3 == exp_b.dest));
        ld = !exp_valid || ordy;
        chk("in_ready", 32'(in_ready), 32'(ld && !hz && !fl));
        last_in_ready = in_ready;
        last_in_ready_b = in_ready_b;
        nb = model(ins);
        @(posedge clk);
        #1;
        if (fl) exp_valid = 1'b0;
        else if (ld) begin exp_valid = iv && !hz; exp_b = nb; end
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("illegal", 32'(illegal), 32'(exp_b.ill));
            chk("alu_mode", 32'(alu_mode), 32'(exp_b.alu));
            chk("mem_mode", 32'(mem_mode), 32'(exp_b.mem));
            chk("flow_mode", 32'(flow_mode), 32'(exp_b.flow));
            chk("write_back_en", 32'(write_back_en), 32'(exp_b.wb));
            chk("reg_dest", 32'(reg_dest), 32'(exp_b.dest));
            chk("shamt", 32'(shamt), 32'(exp_b.shamt));
            chk("data_s1", data_s1, exp_b.s1);
            chk("data_s2", data_s2, exp_b.s2);
            chk("data_s3", data_s3, exp_b.s3);
            chk("jaddress", 32'(jaddress), 32'(exp_b.j));
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] c, input logic [4:0] sh);
        return {op, a, b, c, sh, 6'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                                         input logic [15:0] lit);
        return {op, a, b, lit};
    endfunction

    function automatic logic [4:0] rnd_reg();
        int r = $urandom_range(0, 5);
        return (r < 5) ? 5'(r) : 5'd31;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] op;
        if ($urandom_range(0, 11) == 0) op = 6'(6'h15 + $urandom_range(0, 10));
        else op = legal_ops[$urandom_range(0, 24)];
        return {op, rnd_reg(), rnd_reg(), rnd_reg(), 11'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst wb_en", 32'(write_back_en), 32'd0);
        chk("rst alu_mode", 32'(alu_mode), 32'd0);
        chk("rst mem_mode", 32'(mem_mode), 32'd0);
        chk("rst flow_mode", 32'(flow_mode), 32'd0);
        chk("rst data_s1", data_s1, 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // ADD r1,r2->r3
        rf[1] = 32'd5; rf[2] = 32'd3;
        step(1'b1, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b1, 1'b0);
        chk("add out_valid", 32'(out_valid), 32'd1);
        chk("add alu", 32'(alu_mode), 32'h01);
        chk("add s1", data_s1, 32'd5);
        chk("add s2", data_s2, 32'd3);
        chk("add dest", 32'(reg_dest), 32'd3);
        chk("add wb", 32'(write_back_en), 32'd1);

        // ADD_I with Lit 0xFFF0: sign- vs zero-extended
        step(1'b1, mk_i(ADDI, 5'd1, 5'd7, 16'hFFF0), 1'b1, 1'b0);
        chk("addi sext s2", data_s2, 32'hFFFF_FFF0);
        chk("addi zext s2", data_s2_b, 32'h0000_FFF0);
        chk("addi dest", 32'(reg_dest), 32'd7);

        // LD r4<-[r2] followed by ADD r4,r1->r5
        step(1'b1, mk_i(LD, 5'd4, 5'd2, 16'd0), 1'b1, 1'b0);
        chk("ld mem_mode", 32'(mem_mode), 32'd1);
        step(1'b1, mk_r(ADD, 5'd4, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
        chk("lu in_ready", 32'(last_in_ready), 32'd0);
        chk("lu bubble", 32'(out_valid), 32'd0);
        chk("nostall in_ready", 32'(last_in_ready_b), 32'd1);
        chk("nostall out_valid", 32'(out_valid_b), 32'd1);
        chk("nostall alu", 32'(alu_mode_b), 32'h01);
        step(1'b1, mk_r(ADD, 5'd4, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
        chk("after bubble valid", 32'(out_valid), 32'd1);
        chk("after bubble dest", 32'(reg_dest), 32'd5);
        step(1'b0, 32'd0, 1'b1, 1'b1);

        // Back-pressure: bundle held three cycles
        step(1'b1, mk_r(SUB, 5'd1, 5'd2, 5'd6, 5'd3), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk_r(XOR_, 5'd2, 5'd3, 5'd8, 5'd0), 1'b0, 1'b0);
            chk("hold in_ready", 32'(last_in_ready), 32'd0);
            chk("hold alu", 32'(alu_mode), 32'h02);
            chk("hold shamt", 32'(shamt), 32'd3);
        end
        step(1'b1, mk_r(XOR_, 5'd2, 5'd3, 5'd8, 5'd0), 1'b1, 1'b0);
        chk("release alu", 32'(alu_mode), 32'h05);

        // Illegal opcode then a normal ADD
        step(1'b1, {6'h3F, 26'h155_5555}, 1'b1, 1'b0);
        chk("illegal flag", 32'(illegal), 32'd1);
        chk("illegal wb", 32'(write_back_en), 32'd0);
        chk("illegal alu", 32'(alu_mode), 32'd0);
        step(1'b1, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b1, 1'b0);
        chk("post-illegal flag", 32'(illegal), 32'd0);
        chk("post-illegal alu", 32'(alu_mode), 32'h01);

        // Flush while held, then flush during a bubble
        step(1'b1, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 1'b0);
        step(1'b1, mk_r(SUB, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 1'b1);
        chk("flush held", 32'(out_valid), 32'd0);
        step(1'b1, mk_i(LD, 5'd4, 5'd2, 16'd0), 1'b1, 1'b0);
        step(1'b1, mk_r(ADD, 5'd4, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
        step(1'b1, mk_r(ADD, 5'd4, 5'd1, 5'd5, 5'd0), 1'b1, 1'b1);
        chk("flush bubble valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(last_in_ready), 32'd0);
        step(1'b1, mk_r(ADD, 5'd4, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
        chk("post-flush accept", 32'(out_valid), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom;
            step(($urandom_range(0, 3) != 0), rnd_instr(), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        // Reset pulled mid-stream
        step(1'b1, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 1'b0);
        step(1'b1, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst alu", 32'(alu_mode), 32'd0);
        chk("async rst dest", 32'(reg_dest), 32'd0);
        chk("async rst wb", 32'(write_back_en), 32'd0);
        exp_valid = 1'b0;
        exp_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b1, 1'b0);
        chk("post-rst idle", 32'(out_valid), 32'd0);
        step(1'b1, mk_r(ADD, 5'd1, 5'd2, 5'd3, 5'd0), 1'b1, 1'b0);
        chk("post-rst accept", 32'(out_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
